sq_age_arbiter: RTL
===================

SQ_AGE_ARBITER -- requirements
Module: sq_age_arbiter

Interface
REQ-001 Parameter N, default `SQ_SIZE, number of store-queue entries; SHALL be a power of two, at least 2.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset==0 SHALL force reset state immediately, independent of clock.
REQ-004 req  input  N  per-entry "ready to issue to memory", bit i = SQ entry i.
REQ-005 head_adv  input  1  oldest entry (at head) retires this cycle.
REQ-006 flush  input  1  synchronous squash of all arbiter state.
REQ-007 mem_ready  input  1  memory port accepts the presented grant this cycle.
REQ-008 grant_valid  output  1  a grant is being presented.
REQ-009 grant_idx  output  $clog2(N)  index of the granted entry.
REQ-010 grant_onehot  output  N  one-hot decode of grant_idx, all zero when grant_valid==0.
REQ-011 head  output  $clog2(N)  current head pointer (oldest entry).
REQ-012 issued  output  N  mask of entries already handed to memory and not yet retired.

Function
REQ-013 Eligible vector SHALL be elig = req & ~issued.
REQ-014 Age order SHALL be circular from head: entry i has age rank (i - head) mod N, rank 0 oldest.
REQ-015 Selection SHALL pick the eligible entry with the smallest rank: rotate elig right circularly by head, priority-encode the lowest set bit, add head back mod N.
REQ-016 FSM states SHALL be IDLE and HOLD only.
REQ-017 IDLE: if flush==0 and elig!=0, register the selected index and go to HOLD; otherwise stay in IDLE.
REQ-018 Latency SHALL be exactly one cycle: elig sampled at edge t gives grant_valid==1 after edge t+1.
REQ-019 grant_valid SHALL be 1 exactly in HOLD; grant_idx and grant_onehot SHALL stay stable throughout HOLD, even if req changes or drops.
REQ-020 HOLD with mem_ready==1 and flush==0: set issued[grant_idx] and return to IDLE (one idle cycle between grants).
REQ-021 HOLD with mem_ready==0: stay in HOLD with no state change other than head/issued updates from head_adv.
REQ-022 head_adv==1: clear issued[head] and advance head by 1 mod N, so N-1 wraps to 0.
REQ-023 head_adv while HOLD with grant_idx==head is a protocol violation; the block SHALL still apply REQ-022 and keep the grant; the bench SHALL NOT exercise it.
REQ-024 If head_adv and a handshake (REQ-020) target the same issued bit in one cycle, the set SHALL win.
REQ-025 flush==1: next state SHALL be IDLE, issued SHALL be 0 and head SHALL be 0; flush SHALL override mem_ready, head_adv and new selection in the same cycle, and no handshake SHALL be recorded.
REQ-026 elig==0 in IDLE SHALL leave grant_valid==0 indefinitely without deadlock.
REQ-027 No output SHALL depend combinationally on mem_ready, req, head_adv or flush; all outputs SHALL be driven from registers.

Reset
REQ-028 Reset SHALL set state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, head=0 and issued=0.
REQ-029 Deasserting reset mid-HOLD SHALL leave no grant; the first grant after reset SHALL follow REQ-018.

Verification
REQ-030 Reset: drive req=8'hFF while holding reset low -> grant_valid=0, head=0, issued=0; one cycle after reset rises -> grant_idx=0.
REQ-031 Oldest-first with wrap (N=8): retire 6 entries so head=6, then drive req=8'b1000_0010 -> grant_idx=7, grant_onehot=8'b1000_0000.
REQ-032 Hold stability: grant idx 2 presented, mem_ready=0 for 3 cycles while req toggles -> grant_idx stays 2; mem_ready=1 -> issued[2]=1, next cycle grant_valid=0, and idx 2 is not granted again while req[2]=1.
REQ-033 Retire wrap: 8 head_adv pulses with issued=8'hFF -> head returns to 0 and issued=0.
REQ-034 Flush priority: in HOLD with mem_ready=1 and flush=1 -> next cycle grant_valid=0, issued=0, head=0.
REQ-035 Same-cycle set/clear: head=3, grant_idx=3 handshake while head_adv=1 is not driven; separate test: head_adv on head=2 with handshake on idx 5 -> issued[2]=0, issued[5]=1, head=3.

Source files
------------

// File: rtl/sq_age_arbiter_if.sv
// Store-queue age arbiter bus: request/retire/flush/memory-handshake inputs
// and the registered grant, head and issued-mask outputs.
`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

interface sq_age_arbiter_if #(
  parameter int N = `SQ_SIZE
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic          head_adv;
  logic          flush;
  logic          mem_ready;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  grant_onehot;
  logic [IW-1:0] head;
  logic [N-1:0]  issued;

  modport master (
    output req, head_adv, flush, mem_ready,
    input  grant_valid, grant_idx, grant_onehot, head, issued
  );

  modport slave (
    input  req, head_adv, flush, mem_ready,
    output grant_valid, grant_idx, grant_onehot, head, issued
  );
endinterface

// File: rtl/sq_age_arbiter.sv
// Oldest-first issue arbiter for a circular store queue. Picks the eligible
// entry closest to head, holds the grant until memory accepts it, and tracks
// which entries have been issued until they retire at head.
`ifndef SQ_SIZE
`define SQ_SIZE 8
`endif

module sq_age_arbiter #(
  parameter int N = `SQ_SIZE
) (
  input logic             clock,
  input logic             reset,
  sq_age_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state_q,   state_d;
  logic [IW-1:0] gidx_q,    gidx_d;
  logic [N-1:0]  onehot_q,  onehot_d;
  logic [IW-1:0] head_q,    head_d;
  logic [N-1:0]  issued_q,  issued_d;

  logic [N-1:0]  elig;
  logic [N-1:0]  rot;
  logic [IW-1:0] src_idx;
  logic [IW-1:0] sel_off;
  logic [IW-1:0] sel_idx;
  logic [N-1:0]  sel_onehot;

  // Age-ordered selection: rotate so head sits at bit 0, take the lowest
  // set bit, then rotate the index back. Index sums wrap because N is 2^k.
  always_comb begin
    elig       = bus.req & ~issued_q;
    rot        = '0;
    src_idx    = '0;
    sel_off    = '0;
    sel_onehot = '0;
    for (int k = 0; k < N; k++) begin
      src_idx = IW'(k) + head_q;
      rot[k]  = elig[src_idx];
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) sel_off = IW'(k);
    end
    sel_idx             = sel_off + head_q;
    sel_onehot[sel_idx] = 1'b1;
  end

  // Next-state: flush squashes everything; otherwise retire at head first
  // so that a handshake setting the same issued bit takes precedence.
  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    onehot_d = onehot_q;
    head_d   = head_q;
    issued_d = issued_q;
    if (bus.flush) begin
      state_d  = IDLE;
      onehot_d = '0;
      head_d   = '0;
      issued_d = '0;
    end else begin
      if (bus.head_adv) begin
        issued_d[head_q] = 1'b0;
        head_d           = head_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (elig != '0) begin
            state_d  = HOLD;
            gidx_d   = sel_idx;
            onehot_d = sel_onehot;
          end
        end
        HOLD: begin
          if (bus.mem_ready) begin
            state_d          = IDLE;
            onehot_d         = '0;
            issued_d[gidx_q] = 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          onehot_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
      onehot_q <= '0;
      head_q   <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      onehot_q <= onehot_d;
      head_q   <= head_d;
      issued_q <= issued_d;
    end
  end

  assign bus.grant_valid  = (state_q == HOLD);
  assign bus.grant_idx    = gidx_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.head         = head_q;
  assign bus.issued       = issued_q;
endmodule
